// File: rtl/pa2_seq_gen_if.sv
// pa2_seq_gen_if: command, burst and result signals between the sequence generator and its harness
interface pa2_seq_gen_if;
  logic       start;
  logic [3:0] num;
  logic [3:0] match_cnt;
  logic [3:0] burst_len;
  logic       hit;
  logic       valid;
  logic [3:0] seq;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] hit_cnt;
  modport master (output start, num, match_cnt, burst_len, hit,
                  input  valid, seq, busy, done, pass, hit_cnt);
  modport slave  (input  start, num, match_cnt, burst_len, hit,
                  output valid, seq, busy, done, pass, hit_cnt);
endinterface

// File: rtl/pa2_seq_gen.sv
// pa2_seq_gen: emits a burst with a known number of matching symbols, then counts returned hits
module pa2_seq_gen #(
  parameter logic [3:0] LFSR_SEED = 4'h9,
  parameter int         TIMEOUT   = 20
) (
  input logic         clock,
  input logic         reset,
  pa2_seq_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEND, CHECK, DONE} state_t;
  localparam logic [3:0] SEED = (LFSR_SEED == 4'h0) ? 4'h1 : LFSR_SEED;
  localparam logic [7:0] TMO = 8'(TIMEOUT);
  state_t     state, state_nx;
  logic [3:0] num_q, mc_q, len_q, b, lfsr, fill, len_in, hit_cnt_q;
  logic [7:0] tmo;
  logic       pass_q;
  assign len_in = (bus.burst_len > bus.match_cnt) ? bus.burst_len : bus.match_cnt;
  // filler beats must never alias the matched symbol
  assign fill = (lfsr == num_q) ? (num_q ^ 4'h1) : lfsr;
  assign bus.valid   = state == SEND;
  assign bus.seq     = bus.valid ? ((b < mc_q) ? num_q : fill) : 4'h0;
  assign bus.busy    = state != IDLE;
  assign bus.done    = state == DONE;
  assign bus.pass    = pass_q;
  assign bus.hit_cnt = hit_cnt_q;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = (len_in == 4'd0) ? CHECK : SEND;
      SEND:    if (b == len_q - 4'd1) state_nx = CHECK;
      CHECK:   if (!bus.hit && tmo == 8'd1) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      num_q     <= 4'h0;
      mc_q      <= 4'h0;
      len_q     <= 4'h0;
      b         <= 4'h0;
      lfsr      <= SEED;
      tmo       <= TMO;
      hit_cnt_q <= 4'h0;
      pass_q    <= 1'b0;
    end else begin
      state <= state_nx;
      tmo   <= (state == CHECK && !bus.hit) ? tmo - 8'd1 : TMO;
      if (state == IDLE && bus.start) begin
        num_q     <= bus.num;
        mc_q      <= bus.match_cnt;
        len_q     <= len_in;
        b         <= 4'h0;
        hit_cnt_q <= 4'h0;
        pass_q    <= 1'b0;
      end
      if (state == SEND) begin
        b    <= b + 4'd1;
        lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
      end
      if (state == CHECK && bus.hit && hit_cnt_q != 4'hF) hit_cnt_q <= hit_cnt_q + 4'd1;
      if (state == DONE) pass_q <= hit_cnt_q == mc_q;
    end
  end
endmodule

// File: doc/pa2_seq_gen.md
Name: pa2_seq_gen

Overview:
- Stimulus-side partner of the pa2 match/count detector: drives the `valid`/`seq` burst that detector consumes.
- On a start command, emits a burst of `L` 4-bit symbols with exactly `match_cnt` of them equal to `num`.
- After the burst, counts the detector's returned `hit` pulses and reports pass/fail.
- Sits beside the detector in the pa2 test harness / self-check wrapper.

Parameters:
- LFSR_SEED, 4'h9, initial value of the filler-symbol LFSR; a value of 0 is replaced by 4'h1.
- TIMEOUT, 20, cycles `CHECK` waits with no hit activity before closing the window (legal range 1..255).

Ports:
- clock  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-high reset
- start  in  1  command strobe; sampled only in `IDLE`
- num  in  4  symbol to be matched
- match_cnt  in  4  number of symbols equal to `num` in the burst
- burst_len  in  4  requested burst length
- hit  in  1  hit output returned from the detector
- valid  out  1  burst beat valid
- seq  out  4  burst symbol; 4'h0 whenever `valid`=0
- busy  out  1  high in every state except `IDLE`
- done  out  1  one-cycle completion pulse
- pass  out  1  result of the last run; held until the next accepted start
- hit_cnt  out  4  number of hit cycles observed in the last run (saturates at 15)

Behaviour:
- Reset (async, asserted): state=`IDLE`; `valid`, `seq`, `busy`, `done`, `pass`, `hit_cnt`=0; LFSR=seed. Takes effect immediately, including mid-burst; `valid` drops without waiting for a clock.
- Start acceptance:
  - `start`=1 at a posedge while in `IDLE` latches `num`, `match_cnt`, and `L = max(burst_len, match_cnt)`.
  - Same edge clears `pass` and `hit_cnt`.
  - `start` in any other state is ignored, with no queuing.
- States:
  - `IDLE`: if start and `L`>0, go to `SEND`. If start and `L`=0, go to `CHECK`.
  - `SEND`: `valid`=1 for exactly `L` consecutive cycles, the first of them in the cycle after acceptance. Beat index `b`=0..L-1 is held in a 4-bit counter. After beat L-1, go to `CHECK`.
    - Beats with `b` < `match_cnt`: `seq=num`.
    - Other beats: `seq` = LFSR value, or `num ^ 4'h1` if the LFSR value equals `num`. A filler beat never equals `num`.
    - LFSR: 4-bit Fibonacci, taps x^4+x^3+1. It advances on every `SEND` beat, match or filler, and is never 0.
  - `CHECK`: `valid`=0, `seq`=0.
    - `hit_cnt` increments (saturating at 15) on each cycle with `hit`=1.
    - A timeout counter reloads to `TIMEOUT` on every cycle with `hit`=1 and decrements otherwise.
    - Exit to `DONE` when the counter reaches 0. The window therefore closes `TIMEOUT` quiet cycles after the last hit, or after the `CHECK` entry if no hit occurs.
  - `DONE`: `done`=1 for exactly one cycle; `pass` is registered as (`hit_cnt == match_cnt`). Next state is `IDLE`.
- Guaranteed gap: `valid` is low for at least TIMEOUT+1 cycles between bursts, so the detector returns to `WAIT`.
- `hit` in `IDLE`, `SEND` or `DONE` is ignored and not counted.
- `hit` on the same edge that the counter expires is counted, and the window restarts.
- `num`, `match_cnt` and `burst_len` may change after acceptance with no effect on the run in progress.
- `start` held high continuously gives back-to-back runs: each is accepted on the first `IDLE` cycle after `DONE`.

Test Plan:
- Basic burst: num=5, match_cnt=3, burst_len=6, detector connected -> `valid` high 6 cycles; `seq`=5,5,5 followed by three non-5 values; 3 hit cycles; `done` pulse; `pass`=1, `hit_cnt`=3.
- Zero matches: num=7, match_cnt=0, burst_len=4 -> 4 beats, none equal to 7; no hit; `done` exactly TIMEOUT cycles after `CHECK` entry; `pass`=1, `hit_cnt`=0.
- Length clamp: match_cnt=4, burst_len=2 -> 4 beats, all equal to `num`; `hit_cnt`=4; `pass`=1.
- Injected fault: bench drives `hit` high for 4 cycles during `CHECK` with match_cnt=2 -> `hit_cnt`=4, `pass`=0. Separately, 16 hit cycles -> `hit_cnt` saturates at 15.
- Filler collision: choose `num` equal to the LFSR value at a filler beat (e.g. num=LFSR_SEED with match_cnt=0) -> that beat drives `num^1`; no symbol equals `num`.
- Control robustness:
  - `start` pulsed while `busy`=1 -> ignored; the running burst and its results are unchanged.
  - `reset` asserted mid-`SEND` -> `valid`/`busy` go to 0 asynchronously; the next start produces a correct full run.
